// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: state and owner encodings shared by the RAM arbiter files
package mem_bus_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_ST_IDLE    = 2'b00,
    ARB_ST_GNT_IFU = 2'b01,
    ARB_ST_GNT_LSU = 2'b10,
    ARB_ST_LOCK    = 2'b11
  } arb_st_e;
  localparam logic [1:0] ARB_OWN_NONE = 2'b00;
  localparam logic [1:0] ARB_OWN_IFU  = 2'b01;
  localparam logic [1:0] ARB_OWN_LSU  = 2'b10;
endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// mem_bus_arbiter_pick: one-hot winner select, fixed LSU priority or round-robin under MEM_ARB_RR_EN
module mem_bus_arbiter_pick (
  input  logic ifu_valid,
  input  logic lsu_valid,
`ifdef MEM_ARB_RR_EN
  input  logic prio_ifu,
`endif
  output logic gnt_ifu,
  output logic gnt_lsu
);
  // a tie goes to the requester that lost the previous grant, or always to the LSU without round-robin
  always_comb begin
`ifdef MEM_ARB_RR_EN
    gnt_lsu = lsu_valid && (!ifu_valid || !prio_ifu);
    gnt_ifu = ifu_valid && (!lsu_valid || prio_ifu);
`else
    gnt_lsu = lsu_valid;
    gnt_ifu = ifu_valid && !lsu_valid;
`endif
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single-port RAM between IFU and LSU with RMW lock; MEM_ARB_RR_EN enables round-robin ties
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ifu_req_valid,
  input  logic [AW-1:0] ifu_req_addr,
  output logic          ifu_req_ready,
  output logic          ifu_rsp_valid,
  output logic [DW-1:0] ifu_rsp_rdata,
  input  logic          lsu_req_valid,
  input  logic          lsu_req_wr,
  input  logic          lsu_req_lock,
  input  logic [AW-1:0] lsu_req_addr,
  input  logic [DW-1:0] lsu_req_wdata,
  output logic          lsu_req_ready,
  output logic          lsu_rsp_valid,
  output logic [DW-1:0] lsu_rsp_rdata,
  output logic          ram_valid,
  output logic          ram_wr,
  output logic          ram_rd,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  input  logic          ram_ready,
  output logic [1:0]    arb_owner
);
  arb_st_e       state, state_nxt;
  logic [AW-3:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          wr_q, lock_q;
  logic          gnt_ifu, gnt_lsu, idle, busy, acc_ifu, acc_lsu, done;
`ifdef MEM_ARB_RR_EN
  logic          prio_ifu;
`endif
  mem_bus_arbiter_pick u_pick (
    .ifu_valid (ifu_req_valid),
    .lsu_valid (lsu_req_valid),
`ifdef MEM_ARB_RR_EN
    .prio_ifu  (prio_ifu),
`endif
    .gnt_ifu   (gnt_ifu),
    .gnt_lsu   (gnt_lsu)
  );
  // accept/complete qualifiers; everything is forced quiet while rst_n is low
  always_comb begin
    idle    = rst_n && state == ARB_ST_IDLE;
    busy    = rst_n && (state == ARB_ST_GNT_IFU || state == ARB_ST_GNT_LSU);
    acc_ifu = idle && gnt_ifu;
    acc_lsu = (idle && gnt_lsu) || (rst_n && state == ARB_ST_LOCK && lsu_req_valid);
    done    = busy && ram_ready;
  end
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ARB_ST_IDLE;
    else        state <= state_nxt;
  end
  // next state: grant from IDLE/LOCK, hold grant until the RAM completes
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_ST_IDLE:    state_nxt = acc_lsu ? ARB_ST_GNT_LSU : acc_ifu ? ARB_ST_GNT_IFU : ARB_ST_IDLE;
      ARB_ST_LOCK:    state_nxt = acc_lsu ? ARB_ST_GNT_LSU : ARB_ST_LOCK;
      ARB_ST_GNT_IFU: state_nxt = ram_ready ? ARB_ST_IDLE : ARB_ST_GNT_IFU;
      default:        state_nxt = ram_ready ? (lock_q ? ARB_ST_LOCK : ARB_ST_IDLE) : ARB_ST_GNT_LSU;
    endcase
  end
  // latch the accepted command so it replays unchanged while the RAM stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      lock_q  <= 1'b0;
    end else if (acc_lsu) begin
      addr_q  <= lsu_req_addr[AW-1:2];
      wdata_q <= lsu_req_wdata;
      wr_q    <= lsu_req_wr;
      lock_q  <= lsu_req_lock;
    end else if (acc_ifu) begin
      addr_q  <= ifu_req_addr[AW-1:2];
      wdata_q <= '0;
      wr_q    <= 1'b0;
      lock_q  <= 1'b0;
    end
  end
`ifdef MEM_ARB_RR_EN
  // the loser of each IDLE grant gets priority on the next tie
  always_ff @(posedge clk) begin
    if (!rst_n)                        prio_ifu <= 1'b0;
    else if (acc_ifu || (idle && acc_lsu)) prio_ifu <= acc_lsu;
  end
`endif
  // outputs: handshakes, RAM command replay and response routing
  always_comb begin
    ifu_req_ready = acc_ifu;
    lsu_req_ready = acc_lsu;
    ram_valid     = busy;
    ram_wr        = busy && wr_q;
    ram_rd        = busy && !wr_q;
    ram_addr      = busy ? {2'b00, addr_q} : '0;
    ram_wdata     = busy ? wdata_q : '0;
    ifu_rsp_valid = done && state == ARB_ST_GNT_IFU;
    lsu_rsp_valid = done && state == ARB_ST_GNT_LSU;
    ifu_rsp_rdata = ifu_rsp_valid ? ram_rdata : '0;
    lsu_rsp_rdata = (lsu_rsp_valid && !wr_q) ? ram_rdata : '0;
    arb_owner     = !rst_n ? ARB_OWN_NONE :
                    state == ARB_ST_GNT_IFU ? ARB_OWN_IFU :
                    state == ARB_ST_IDLE ? ARB_OWN_NONE : ARB_OWN_LSU;
  end
endmodule
